// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-period helpers.
// Used by the transmitter and its baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last and second-to-last
// cycle of every bit period. A synchronous restart realigns the period to a new frame.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 86
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick,
    output logic bit_pre
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == CNT_LAST);
    assign bit_pre  = (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// One byte per valid/ready handshake; back-to-back frames leave no idle time on the line.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | line high, ready for a byte; also the final cycle of the stop bits
//   ST_START  | driving the start bit (0)
//   ST_DATA   | driving shift_q[0], bit_idx_q counts 0..7
//   ST_PARITY | driving the precomputed parity bit
//   ST_STOP   | driving stop bits (1), stop_idx_q selects first/second
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUDRATE  = 115200,
    parameter int CLK_FREQ  = 10000000,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);
    localparam logic STOP_LAST  = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLK_FREQ/BAUDRATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [2:0]  bit_idx_q;
    logic        stop_idx_q;
    logic        tx_q;
    logic        done_q;

    logic        handshake;
    logic        bit_tick;
    logic        bit_pre;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = ~in_ready;
    assign handshake = in_valid && in_ready;
    assign tx        = tx_q;
    assign done      = done_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (handshake),
        .bit_tick(bit_tick),
        .bit_pre (bit_pre)
    );

    // The last stop bit hands its final cycle to IDLE so a waiting producer's
    // handshake lands exactly on the stop-bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (in_valid) begin
                        shift_q    <= in_data;
                        par_q      <= parity_bit(in_data, PARITY);
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        tx_q       <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if ((stop_idx_q == STOP_LAST) && bit_pre) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (bit_tick) begin
                        stop_idx_q <= 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameterisations driven with directed and random
// bytes, each frame compared cycle by cycle against a bit-list model of the serial frame.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid_a;
    logic [7:0] in_data_a [4];
    logic [3:0] tx_a, rdy_a, busy_a, done_a;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int cf_a  [4] = '{10000000, 10000000, 1000, 5};
    int br_a  [4] = '{115200,   115200,   300,  2};
    int par_a [4] = '{0, 2, 1, 0};
    int stp_a [4] = '{1, 2, 1, 2};

    always #5 clk = ~clk;

    uart_tx #(.BAUDRATE(115200), .CLK_FREQ(10000000), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[0]), .in_valid(in_valid_a[0]),
        .in_ready(rdy_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .done(done_a[0]));
    uart_tx #(.BAUDRATE(115200), .CLK_FREQ(10000000), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[1]), .in_valid(in_valid_a[1]),
        .in_ready(rdy_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .done(done_a[1]));
    uart_tx #(.BAUDRATE(300), .CLK_FREQ(1000), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[2]), .in_valid(in_valid_a[2]),
        .in_ready(rdy_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .done(done_a[2]));
    uart_tx #(.BAUDRATE(2), .CLK_FREQ(5), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[3]), .in_valid(in_valid_a[3]),
        .in_ready(rdy_a[3]), .tx(tx_a[3]), .busy(busy_a[3]), .done(done_a[3]));

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sends one byte on instance d and checks the whole frame. nv/nd are the in_valid/in_data
    // values presented on the done cycle (nv=1 chains the next frame). abort_at >= 0 stops early.
    task automatic send(input int d, input logic [7:0] data, input bit nv,
                        input logic [7:0] nd, input int abort_at);
        int cpb, total, wait_n, good, done_bad, rdy_bad, busy_bad, ones;
        int exp_bits[$];
        cpb = cf_a[d] / br_a[d];
        ones = $countones(data);
        exp_bits.push_back(0);
        for (int k = 0; k < 8; k++) exp_bits.push_back(int'(data[k]));
        if (par_a[d] == 2) exp_bits.push_back(ones % 2);
        if (par_a[d] == 1) exp_bits.push_back(1 - (ones % 2));
        for (int s = 0; s < stp_a[d]; s++) exp_bits.push_back(1);
        total = exp_bits.size() * cpb;

        in_valid_a[d] = 1'b1;
        in_data_a[d]  = data;
        wait_n = 0;
        while (rdy_a[d] !== 1'b1 && wait_n < 4000) begin
            @(negedge clk);
            wait_n++;
        end
        check($sformatf("d%0d_handshake_wait", d), int'(wait_n < 4000), 1);
        if (wait_n >= 4000) return;

        @(posedge clk);
        #1;
        in_valid_a[d] = 1'($urandom);
        in_data_a[d]  = 8'($urandom);
        good = 0; done_bad = 0; rdy_bad = 0; busy_bad = 0;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (tx_a[d] === 1'(exp_bits[i / cpb])) good++;
            if (done_a[d] !== (i == total - 1)) done_bad++;
            if (rdy_a[d]  !== (i == total - 1)) rdy_bad++;
            if (busy_a[d] !== (i != total - 1)) busy_bad++;
            if (i == abort_at) begin
                in_valid_a[d] = 1'b0;
                return;
            end
            if ((i + 1) % cpb == 0) begin
                check($sformatf("d%0d_byte%02h_bit%0d_cycles", d, data, i / cpb), good, cpb);
                good = 0;
            end
            if (i < total - 2) begin
                in_valid_a[d] = 1'($urandom);
                in_data_a[d]  = 8'($urandom);
            end else if (i == total - 2) begin
                in_valid_a[d] = nv;
                in_data_a[d]  = nd;
            end
        end
        check($sformatf("d%0d_byte%02h_done_pulse_errs", d, data), done_bad, 0);
        check($sformatf("d%0d_byte%02h_ready_errs", d, data), rdy_bad, 0);
        check($sformatf("d%0d_byte%02h_busy_errs", d, data), busy_bad, 0);
    endtask

    // Reset is applied between clock edges, so its effect must be visible before any edge.
    task automatic reset_abort(input int d);
        int done_bad, line_bad;
        #2;
        rst_n = 1'b0;
        #1;
        check($sformatf("d%0d_rst_async_tx", d), int'(tx_a[d]), 1);
        check($sformatf("d%0d_rst_async_busy", d), int'(busy_a[d]), 0);
        check($sformatf("d%0d_rst_async_ready", d), int'(rdy_a[d]), 1);
        done_bad = 0; line_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_a !== 4'h0) done_bad++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done_a !== 4'h0) done_bad++;
            if (tx_a[d] !== 1'b1 || rdy_a[d] !== 1'b1) line_bad++;
        end
        check($sformatf("d%0d_rst_no_done", d), done_bad, 0);
        check($sformatf("d%0d_rst_line_idle", d), line_bad, 0);
    endtask

    initial begin
        logic [7:0] cur, nxt;
        int tx_bad, rdy_bad, busy_bad, done_bad;

        rst_n = 1'b0;
        in_valid_a = 4'h0;
        for (int d = 0; d < 4; d++) in_data_a[d] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx_a), 15);
        check("reset_ready", int'(rdy_a), 15);
        check("reset_busy", int'(busy_a), 0);
        check("reset_done", int'(done_a), 0);
        rst_n = 1'b1;

        tx_bad = 0; rdy_bad = 0; busy_bad = 0; done_bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_a   !== 4'hF) tx_bad++;
            if (rdy_a  !== 4'hF) rdy_bad++;
            if (busy_a !== 4'h0) busy_bad++;
            if (done_a !== 4'h0) done_bad++;
        end
        check("idle_tx_errs", tx_bad, 0);
        check("idle_ready_errs", rdy_bad, 0);
        check("idle_busy_errs", busy_bad, 0);
        check("idle_done_errs", done_bad, 0);

        send(0, 8'hA5, 1'b0, 8'h00, -1);
        send(1, 8'hA5, 1'b0, 8'h00, -1);
        send(2, 8'hA5, 1'b0, 8'h00, -1);

        send(0, 8'h00, 1'b1, 8'hFF, -1);
        send(0, 8'hFF, 1'b0, 8'h00, -1);

        cur = 8'($urandom);
        for (int k = 0; k < 10; k++) begin
            nxt = 8'($urandom);
            send(2, cur, (k % 3) != 2, nxt, -1);
            cur = nxt;
        end
        cur = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            nxt = 8'($urandom);
            send(3, cur, k < 7, nxt, -1);
            cur = nxt;
        end

        send(0, 8'h0F, 1'b0, 8'h00, 4 * 86 + 40);
        reset_abort(0);
        send(0, 8'h3C, 1'b0, 8'h00, -1);

        send(1, 8'($urandom), 1'b0, 8'h00, 40);
        reset_abort(1);
        cur = 8'($urandom);
        nxt = 8'($urandom);
        send(1, cur, 1'b1, nxt, -1);
        send(1, nxt, 1'b0, 8'h00, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
